// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - mm:ss.cc BCD countdown timer with load/start/stop control
// Four-state FSM (IDLE/RUN/PAUSE/DONE) with prescaled 0.01 s ticks and clamped preset loading.
module countdown_timer #(
  parameter int TICK_DIV = 500000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       stop,
  input  logic       load,
  input  logic [3:0] ld_d,
  input  logic [3:0] ld_e,
  input  logic [3:0] ld_f,
  input  logic [3:0] ld_g,
  input  logic [3:0] ld_h,
  input  logic [3:0] ld_i,
  output logic [3:0] d,
  output logic [3:0] e,
  output logic [3:0] f,
  output logic [3:0] g,
  output logic [3:0] h,
  output logic [3:0] i,
  output logic       running,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  localparam logic [18:0] PRESC_TOP = 19'(TICK_DIV - 1);

  state_t          r_state, w_state_nxt;
  logic [18:0]     r_presc, w_presc_nxt;
  // Digit index 5 is d (tens of minutes) down to index 0 is i (hundredths).
  logic [5:0][3:0] r_dig, w_dig_nxt, w_dig_ld, w_dig_dec;
  logic            w_borrow;
  logic            w_nonzero;
  logic            w_dec_zero;
  logic            w_at_top;

  assign w_dig_ld[5] = (ld_d > 4'd5) ? 4'd5 : ld_d;
  assign w_dig_ld[4] = (ld_e > 4'd9) ? 4'd9 : ld_e;
  assign w_dig_ld[3] = (ld_f > 4'd5) ? 4'd5 : ld_f;
  assign w_dig_ld[2] = (ld_g > 4'd9) ? 4'd9 : ld_g;
  assign w_dig_ld[1] = (ld_h > 4'd9) ? 4'd9 : ld_h;
  assign w_dig_ld[0] = (ld_i > 4'd9) ? 4'd9 : ld_i;

  // Ripple borrow from hundredths upward; tens digits wrap to 5, others to 9.
  always_comb begin
    w_dig_dec = r_dig;
    w_borrow  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (w_borrow) begin
        if (r_dig[k] == 4'd0) begin
          w_dig_dec[k] = (k == 3 || k == 5) ? 4'd5 : 4'd9;
        end else begin
          w_dig_dec[k] = r_dig[k] - 4'd1;
          w_borrow     = 1'b0;
        end
      end
    end
  end

  assign w_nonzero  = |r_dig;
  assign w_dec_zero = ~|w_dig_dec;
  assign w_at_top   = (r_presc == PRESC_TOP);

  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_dig_nxt   = r_dig;
    case (r_state)
      IDLE: begin
        if (!stop) begin
          if (load) begin
            w_dig_nxt   = w_dig_ld;
            w_presc_nxt = '0;
          end else if (start && w_nonzero) begin
            w_state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (stop) begin
          w_state_nxt = PAUSE;
        end else if (w_at_top) begin
          w_presc_nxt = '0;
          if (w_nonzero) begin
            w_dig_nxt = w_dig_dec;
            if (w_dec_zero) w_state_nxt = DONE;
          end else begin
            w_state_nxt = DONE;
          end
        end else begin
          w_presc_nxt = r_presc + 19'd1;
        end
      end
      PAUSE: begin
        if (!stop) begin
          if (load) begin
            w_dig_nxt   = w_dig_ld;
            w_presc_nxt = '0;
            w_state_nxt = IDLE;
          end else if (start && w_nonzero) begin
            w_state_nxt = RUN;
          end
        end
      end
      DONE: begin
        if (!stop && load) begin
          w_dig_nxt   = w_dig_ld;
          w_presc_nxt = '0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_presc <= '0;
      r_dig   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_presc <= w_presc_nxt;
      r_dig   <= w_dig_nxt;
    end
  end

  assign d       = r_dig[5];
  assign e       = r_dig[4];
  assign f       = r_dig[3];
  assign g       = r_dig[2];
  assign h       = r_dig[1];
  assign i       = r_dig[0];
  assign running = (r_state == RUN);
  assign done    = (r_state == DONE);

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - scoreboard bench for countdown_timer
// Expected {running, done, d..i} vectors are queued with stimulus and compared after each edge.
module tb_countdown_timer;

  logic       clk;
  logic       reset_n;
  logic       start, stop, load;
  logic [3:0] ld_d, ld_e, ld_f, ld_g, ld_h, ld_i;
  logic [3:0] d, e, f, g, h, i;
  logic       running, done;

  typedef struct {
    string       tag;
    logic [25:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  int       n_vec;
  int       n_err;

  countdown_timer #(.TICK_DIV(4)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .stop    (stop),
    .load    (load),
    .ld_d    (ld_d),
    .ld_e    (ld_e),
    .ld_f    (ld_f),
    .ld_g    (ld_g),
    .ld_h    (ld_h),
    .ld_i    (ld_i),
    .d       (d),
    .e       (e),
    .f       (f),
    .g       (g),
    .h       (h),
    .i       (i),
    .running (running),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [25:0] got, input logic [25:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got run=%0b done=%0b %h, want run=%0b done=%0b %h",
               tag, got[25], got[24], got[23:0], exp[25], exp[24], exp[23:0]);
    end
  endtask

  task automatic sb_push(input string tag, input logic [1:0] rd, input logic [23:0] val);
    sb_item_t it;
    it.tag = tag;
    it.exp = {rd, val};
    sb_q.push_back(it);
  endtask

  task automatic sb_drain();
    sb_item_t it;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      check_vec(it.tag, {running, done, d, e, f, g, h, i}, it.exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [1:0] rd, input logic [23:0] val);
    sb_push(tag, rd, val);
    sb_drain();
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_ld(input logic [23:0] v);
    {ld_d, ld_e, ld_f, ld_g, ld_h, ld_i} = v;
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    reset_n = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    load    = 1'b0;
    set_ld(24'h000000);
    #1;
    expect_out("reset", 2'b00, 24'h000000);
    cyc(2);
    reset_n = 1'b1;

    // Short countdown to zero
    set_ld(24'h000003); load = 1'b1; cyc(1); load = 1'b0;
    expect_out("ld3", 2'b00, 24'h000003);
    start = 1'b1; cyc(1); start = 1'b0;
    expect_out("run3", 2'b10, 24'h000003);
    cyc(3); expect_out("pre_tick", 2'b10, 24'h000003);
    cyc(1); expect_out("tick_02", 2'b10, 24'h000002);
    cyc(4); expect_out("tick_01", 2'b10, 24'h000001);
    cyc(3); expect_out("pre_zero", 2'b10, 24'h000001);
    cyc(1); expect_out("done_zero", 2'b01, 24'h000000);
    cyc(5); expect_out("zero_hold", 2'b01, 24'h000000);

    // Clamped load from DONE, tick from max value, PAUSE load, start at zero
    {ld_d, ld_e, ld_f, ld_g, ld_h, ld_i} = {4'd7, 4'd12, 4'd9, 4'd15, 4'd10, 4'd11};
    load = 1'b1; cyc(1); load = 1'b0;
    expect_out("clamp", 2'b00, 24'h595999);
    start = 1'b1; cyc(1); start = 1'b0;
    expect_out("run_max", 2'b10, 24'h595999);
    cyc(4); expect_out("max_tick", 2'b10, 24'h595998);
    stop = 1'b1; cyc(1); stop = 1'b0;
    expect_out("pause_max", 2'b00, 24'h595998);
    set_ld(24'h000000); load = 1'b1; cyc(1); load = 1'b0;
    expect_out("pause_load", 2'b00, 24'h000000);
    start = 1'b1; cyc(2); start = 1'b0;
    expect_out("zero_start", 2'b00, 24'h000000);

    // Full borrow chain, pause at prescaler 2, resume keeps partial tick
    set_ld(24'h010000); load = 1'b1; cyc(1); load = 1'b0;
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(4); expect_out("borrow", 2'b10, 24'h005999);
    cyc(2);
    stop = 1'b1; cyc(1); stop = 1'b0;
    expect_out("pause", 2'b00, 24'h005999);
    cyc(10); expect_out("pause_hold", 2'b00, 24'h005999);
    start = 1'b1; cyc(1); start = 1'b0;
    expect_out("resume", 2'b10, 24'h005999);
    cyc(1); expect_out("resume_p3", 2'b10, 24'h005999);
    cyc(1); expect_out("resume_tick", 2'b10, 24'h005998);

    // Stop on the tick cycle, then all three controls together in PAUSE
    cyc(3); expect_out("pre_stop_tick", 2'b10, 24'h005998);
    stop = 1'b1; cyc(1); stop = 1'b0;
    expect_out("stop_tick", 2'b00, 24'h005998);
    set_ld(24'h123456);
    start = 1'b1; stop = 1'b1; load = 1'b1; cyc(1);
    start = 1'b0; stop = 1'b0; load = 1'b0;
    expect_out("all_three", 2'b00, 24'h005998);
    start = 1'b1; cyc(1); start = 1'b0;
    expect_out("resume2", 2'b10, 24'h005998);
    cyc(1); expect_out("held_partial", 2'b10, 24'h005997);

    // DONE then load with start
    stop = 1'b1; cyc(1); stop = 1'b0;
    set_ld(24'h000001); load = 1'b1; cyc(1); load = 1'b0;
    start = 1'b1; cyc(1); start = 1'b0;
    expect_out("run1", 2'b10, 24'h000001);
    cyc(4); expect_out("done1", 2'b01, 24'h000000);
    set_ld(24'h000012); load = 1'b1; start = 1'b1; cyc(1); load = 1'b0;
    expect_out("done_load", 2'b00, 24'h000012);
    cyc(1); start = 1'b0;
    expect_out("idle_start", 2'b10, 24'h000012);

    // Asynchronous reset between edges during RUN
    cyc(1);
    #3 reset_n = 1'b0;
    #1 expect_out("async_rst", 2'b00, 24'h000000);
    cyc(1);
    expect_out("rst_hold", 2'b00, 24'h000000);
    reset_n = 1'b1;
    set_ld(24'h000002); load = 1'b1; cyc(1); load = 1'b0;
    start = 1'b1; cyc(1); start = 1'b0;
    expect_out("post_rst_run", 2'b10, 24'h000002);
    cyc(4); expect_out("post_rst_t1", 2'b10, 24'h000001);
    cyc(4); expect_out("post_rst_done", 2'b01, 24'h000000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
